div_iter_unit: RTL and testbench

- Multi-cycle radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits downstream of the decode/control stage, beside the single-cycle ALU. It receives the operands and the divide-class operation once the decoder selects a divide op, and returns the result together with the destination register tag for writeback.
- Asserts busy so the pipeline can stall fetch and decode while an operation is in flight.

---
 rtl/div_iter_unit.sv | 230 +++++++++++++++++++++++
 tb/tb_div_iter_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter_unit.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Returns one quotient bit per cycle; divide-by-zero and signed overflow bypass the iteration.
module div_iter_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    input  logic [TAG_WIDTH-1:0]  tag_i,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [TAG_WIDTH-1:0]  tag_o
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]         CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]         CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]         CNT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] ZERO_W   = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ONE_W    = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] ONES_W   = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] MIN_W    = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [TAG_WIDTH-1:0]  ZERO_T   = {TAG_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
    logic [DATA_WIDTH-1:0] dvd_q, dvd_d;
    logic [TAG_WIDTH-1:0]  tag_hold_q, tag_hold_d;
    logic                  is_rem_q, is_rem_d;
    logic                  qneg_q, qneg_d;
    logic                  rneg_q, rneg_d;
    logic                  dz_q, dz_d;
    logic                  ovf_q, ovf_d;

    logic                  accept_s;
    logic                  signed_op_s;
    logic                  dd_neg_s, ds_neg_s;
    logic                  dz_s, ovf_s;
    logic [DATA_WIDTH-1:0] dd_abs_s, ds_abs_s;
    logic [DATA_WIDTH:0]   r_shift_s, diff_s;
    logic [DATA_WIDTH-1:0] q_val_s, r_val_s, fin_val_s;

    // The done cycle keeps busy high, so a start there is ignored by the busy gate.
    assign accept_s    = (state_q == S_IDLE) && !busy_q && start && !flush;
    assign signed_op_s = ~op[0];
    assign dd_neg_s    = signed_op_s & dividend[DATA_WIDTH-1];
    assign ds_neg_s    = signed_op_s & divisor[DATA_WIDTH-1];
    assign dd_abs_s    = dd_neg_s ? (~dividend + ONE_W) : dividend;
    assign ds_abs_s    = ds_neg_s ? (~divisor + ONE_W) : divisor;
    assign dz_s        = (divisor == ZERO_W);
    assign ovf_s       = signed_op_s && (dividend == MIN_W) && (divisor == ONES_W);

    // Restoring step on W+1 bits so the compare never overflows.
    assign r_shift_s = {rem_q, a_q[DATA_WIDTH-1]};
    assign diff_s    = r_shift_s - {1'b0, dvs_q};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = (dz_s || ovf_s) ? S_FIN : S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Final sign fix-up and RISC-V special-case results.
    always_comb begin
        q_val_s = qneg_q ? (~a_q + ONE_W) : a_q;
        r_val_s = rneg_q ? (~rem_q + ONE_W) : rem_q;
        if (dz_q) begin
            q_val_s = ONES_W;
            r_val_s = dvd_q;
        end else if (ovf_q) begin
            q_val_s = MIN_W;
            r_val_s = ZERO_W;
        end else begin
            q_val_s = q_val_s;
            r_val_s = r_val_s;
        end
        fin_val_s = is_rem_q ? r_val_s : q_val_s;
    end

    // Output logic: results are captured at the end of FIN unless flushed.
    always_comb begin
        done_d   = (state_q == S_FIN) && !flush;
        busy_d   = (state_d != S_IDLE) || done_d;
        result_d = result_q;
        tag_d    = tag_q;
        if (done_d) begin
            result_d = fin_val_s;
            tag_d    = tag_hold_q;
        end else begin
            result_d = result_q;
            tag_d    = tag_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= ZERO_W;
            tag_q    <= ZERO_T;
        end else begin
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            tag_q    <= tag_d;
        end
    end

    // Operand capture on accept, one quotient bit per CALC cycle (quotient shifts into a_q).
    always_comb begin
        cnt_d      = cnt_q;
        a_d        = a_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        dvd_d      = dvd_q;
        tag_hold_d = tag_hold_q;
        is_rem_d   = is_rem_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        dz_d       = dz_q;
        ovf_d      = ovf_q;
        if (accept_s) begin
            cnt_d      = CNT_ZERO;
            a_d        = dd_abs_s;
            rem_d      = ZERO_W;
            dvs_d      = ds_abs_s;
            dvd_d      = dividend;
            tag_hold_d = tag_i;
            is_rem_d   = op[1];
            qneg_d     = dd_neg_s ^ ds_neg_s;
            rneg_d     = dd_neg_s;
            dz_d       = dz_s;
            ovf_d      = ovf_s;
        end else if (state_q == S_CALC) begin
            cnt_d = cnt_q + CNT_ONE;
            if (!diff_s[DATA_WIDTH]) begin
                rem_d = diff_s[DATA_WIDTH-1:0];
                a_d   = {a_q[DATA_WIDTH-2:0], 1'b1};
            end else begin
                rem_d = r_shift_s[DATA_WIDTH-1:0];
                a_d   = {a_q[DATA_WIDTH-2:0], 1'b0};
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= CNT_ZERO;
            a_q        <= ZERO_W;
            rem_q      <= ZERO_W;
            dvs_q      <= ZERO_W;
            dvd_q      <= ZERO_W;
            tag_hold_q <= ZERO_T;
            is_rem_q   <= 1'b0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            dz_q       <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            rem_q      <= rem_d;
            dvs_q      <= dvs_d;
            dvd_q      <= dvd_d;
            tag_hold_q <= tag_hold_d;
            is_rem_q   <= is_rem_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            dz_q       <= dz_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign tag_o  = tag_q;

endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit: directed cases plus a randomized sweep
// against an arithmetic reference model.
module tb_div_iter_unit;

    localparam int W = 32;
    localparam int T = 5;
    localparam logic [W-1:0] MIN_V  = 32'h8000_0000;
    localparam logic [W-1:0] ONES_V = 32'hFFFF_FFFF;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [T-1:0] tag_i;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [T-1:0] tag_o;

    int tests;
    int fails;

    div_iter_unit #(.DATA_WIDTH(W), .TAG_WIDTH(T)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .dividend(dividend), .divisor(divisor), .tag_i(tag_i), .flush(flush),
        .busy(busy), .done(done), .result(result), .tag_o(tag_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: RISC-V M-extension semantics via native arithmetic.
    function automatic logic [W-1:0] ref_model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        sa = a;
        sb = b;
        case (o)
            2'b00: begin
                if (b == 32'd0) return ONES_V;
                else if (a == MIN_V && b == ONES_V) return MIN_V;
                else return sa / sb;
            end
            2'b01: begin
                if (b == 32'd0) return ONES_V;
                else return a / b;
            end
            2'b10: begin
                if (b == 32'd0) return a;
                else if (a == MIN_V && b == ONES_V) return 32'd0;
                else return sa % sb;
            end
            default: begin
                if (b == 32'd0) return a;
                else return a % b;
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == 32'd0) return 2;
        if (!o[0] && a == MIN_V && b == ONES_V) return 2;
        return W + 2;
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 9))
            0: return 32'd0;
            1: return 32'd1;
            2: return ONES_V;
            3: return MIN_V;
            4: return 32'h7FFF_FFFF;
            5: return 32'd0 + $urandom_range(0, 20);
            6: return 32'd0 - $urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    // Presents one start, then observes 40 cycles; cycle c is E0+c.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [T-1:0] t, output logic [W-1:0] res, output logic [T-1:0] tg,
                         output int lat, output int busy_cnt, output int dones);
        op = o; dividend = a; divisor = b; tag_i = t; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; busy_cnt = 0; dones = 0; res = 32'd0; tg = 5'd0;
        for (int c = 1; c <= 40; c++) begin
            if (busy) busy_cnt++;
            if (done) begin
                dones++;
                if (lat == 0) begin
                    lat = c; res = result; tg = tag_o;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
        tests++; if (result !== 32'd0) begin fails++; $display("FAIL reset_result got=%h exp=0", result); end
        tests++; if (tag_o !== 5'd0) begin fails++; $display("FAIL reset_tag got=%h exp=0", tag_o); end
    endtask

    task automatic test_unsigned();
        logic [W-1:0] res; logic [T-1:0] tg; int lat, bc, dn;
        issue(2'b01, 32'd100, 32'd7, 5'd3, res, tg, lat, bc, dn);
        tests++; if (res !== 32'd14) begin fails++; $display("FAIL divu_result got=%h exp=%h", res, 32'd14); end
        tests++; if (tg !== 5'd3) begin fails++; $display("FAIL divu_tag got=%h exp=3", tg); end
        tests++; if (lat !== 34) begin fails++; $display("FAIL divu_latency got=%0d exp=34", lat); end
        tests++; if (bc !== 34) begin fails++; $display("FAIL divu_busy_cycles got=%0d exp=34", bc); end
        tests++; if (dn !== 1) begin fails++; $display("FAIL divu_done_count got=%0d exp=1", dn); end
        issue(2'b11, 32'd100, 32'd7, 5'd9, res, tg, lat, bc, dn);
        tests++; if (res !== 32'd2) begin fails++; $display("FAIL remu_result got=%h exp=2", res); end
        tests++; if (tg !== 5'd9) begin fails++; $display("FAIL remu_tag got=%h exp=9", tg); end
    endtask

    task automatic test_signed_and_special();
        logic [1:0]   ops  [8] = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 2'b01, 2'b11, 2'b00};
        logic [W-1:0] as   [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, MIN_V, MIN_V, 32'h1234, 32'h1234, 32'd5};
        logic [W-1:0] bs   [8] = '{32'd2, 32'd2, 32'hFFFF_FFFE, ONES_V, ONES_V, 32'd0, 32'd0, 32'd0};
        logic [W-1:0] exps [8] = '{32'hFFFF_FFFD, ONES_V, 32'd1, MIN_V, 32'd0, ONES_V, 32'h1234, ONES_V};
        int           lats [8] = '{34, 34, 34, 2, 2, 2, 2, 2};
        logic [W-1:0] res; logic [T-1:0] tg; int lat, bc, dn;
        for (int i = 0; i < 8; i++) begin
            issue(ops[i], as[i], bs[i], 5'(i + 10), res, tg, lat, bc, dn);
            tests++; if (res !== exps[i]) begin fails++; $display("FAIL directed_%0d_result got=%h exp=%h", i, res, exps[i]); end
            tests++; if (lat !== lats[i]) begin fails++; $display("FAIL directed_%0d_latency got=%0d exp=%0d", i, lat, lats[i]); end
            tests++; if (bc !== lats[i]) begin fails++; $display("FAIL directed_%0d_busy got=%0d exp=%0d", i, bc, lats[i]); end
        end
    endtask

    task automatic test_start_while_busy();
        int lat, dn; logic [W-1:0] res;
        op = 2'b01; dividend = 32'd50; divisor = 32'd5; tag_i = 5'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; lat = 0; dn = 0; res = 32'd0;
        for (int c = 1; c <= 45; c++) begin
            if (c == 10) begin start = 1'b1; dividend = 32'd9; divisor = 32'd3; end
            if (c == 11) start = 1'b0;
            if (done) begin dn++; if (lat == 0) begin lat = c; res = result; end end
            @(posedge clk); #1;
        end
        start = 1'b0;
        tests++; if (res !== 32'd10) begin fails++; $display("FAIL busy_start_result got=%h exp=a", res); end
        tests++; if (lat !== 34) begin fails++; $display("FAIL busy_start_latency got=%0d exp=34", lat); end
        tests++; if (dn !== 1) begin fails++; $display("FAIL busy_start_done_count got=%0d exp=1", dn); end
    endtask

    task automatic test_flush();
        logic [W-1:0] prev; logic [W-1:0] res; logic [T-1:0] tg; int lat, bc, dn;
        prev = result;
        dn = 0;
        op = 2'b01; dividend = 32'd1000; divisor = 32'd7; tag_i = 5'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            if (done) dn++;
            if (c == 15) flush = 1'b1;
            @(posedge clk); #1;
        end
        flush = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_busy got=%b exp=0", busy); end
        tests++; if (result !== prev) begin fails++; $display("FAIL flush_result_hold got=%h exp=%h", result, prev); end
        issue(2'b01, 32'd9, 32'd3, 5'd8, res, tg, lat, bc, dn);
        tests++; if (res !== 32'd3) begin fails++; $display("FAIL after_flush_result got=%h exp=3", res); end
        tests++; if (dn !== 1) begin fails++; $display("FAIL after_flush_done_count got=%0d exp=1", dn); end
        flush = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_blocks_start got=%b exp=0", busy); end
    endtask

    task automatic test_async_reset();
        int dn;
        op = 2'b01; dividend = 32'd77; divisor = 32'd3; tag_i = 5'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL arst_busy got=%b exp=0", busy); end
        tests++; if (result !== 32'd0) begin fails++; $display("FAIL arst_result got=%h exp=0", result); end
        tests++; if (tag_o !== 5'd0) begin fails++; $display("FAIL arst_tag got=%h exp=0", tag_o); end
        #3 rst = 1'b0;
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        tests++; if (dn !== 0) begin fails++; $display("FAIL arst_no_done got=%0d exp=0", dn); end
    endtask

    task automatic test_random();
        logic [1:0] o; logic [W-1:0] a, b, e; logic [T-1:0] t;
        logic [W-1:0] res; logic [T-1:0] tg; int lat, bc, dn, el;
        for (int i = 0; i < 1000; i++) begin
            o = 2'($urandom_range(0, 3));
            a = pick_operand();
            b = pick_operand();
            t = 5'($urandom_range(0, 31));
            e = ref_model(o, a, b);
            el = ref_latency(o, a, b);
            issue(o, a, b, t, res, tg, lat, bc, dn);
            tests++;
            if (res !== e || tg !== t || lat !== el || dn !== 1) begin
                fails++;
                $display("FAIL random_%0d op=%0d a=%h b=%h got=%h/tag%0d/lat%0d/dn%0d exp=%h/tag%0d/lat%0d/dn1",
                         i, o, a, b, res, tg, lat, dn, e, t, el);
            end
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00;
        dividend = 32'd0; divisor = 32'd0; tag_i = 5'd0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_unsigned();
        test_signed_and_special();
        test_start_while_busy();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
